// File: rtl/seq_det_rr_sched.sv
// seq_det_rr_sched
//   Shares one Mealy "1010" overlapping detector across NCH serial bit
//   channels. A round-robin arbiter grants one valid channel per cycle. Each
//   channel's 2-bit FSM state lives in a context table. Only the granted
//   channel's context is advanced in a cycle.
//
//   Optional feature: define HIT_COUNT_EN to add a saturating CNTW-bit hit
//   counter per channel, read back through cnt_sel_i / cnt_val_o.
//
// Ports
//   clk_i       rising-edge clock
//   reset_i     synchronous active-high reset
//   ch_valid_i  [NCH]  channel i offers ch_bit_i[i]
//   ch_bit_i    [NCH]  serial data bits
//   ch_ready_o  [NCH]  one-hot grant (0 while reset or nothing eligible)
//   ch_clear_i  [NCH]  force channel context to S0 and zero its counter
//   det_valid_o        a bit was consumed last cycle
//   det_ch_o    [CHW]  channel of that bit
//   det_hit_o          that bit completed "1010"
//   cnt_sel_i   [CHW]  counter readout select
//   cnt_val_o   [CNTW] hit count of cnt_sel_i (0 when feature disabled)
module seq_det_rr_sched #(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int CNTW = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [NCH-1:0]  ch_valid_i,
  input  logic [NCH-1:0]  ch_bit_i,
  output logic [NCH-1:0]  ch_ready_o,
  input  logic [NCH-1:0]  ch_clear_i,
  output logic            det_valid_o,
  output logic [CHW-1:0]  det_ch_o,
  output logic            det_hit_o,
  input  logic [CHW-1:0]  cnt_sel_i,
  output logic [CNTW-1:0] cnt_val_o
);

  typedef enum logic [1:0] {S0, S1, S2, S3} st_e;

  st_e [NCH-1:0] ctx_q;
  logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
  logic           det_valid_q, det_hit_q;
  logic [CHW-1:0] det_ch_q;

  logic [NCH-1:0] elig;
  logic [CHW-1:0] grant;
  logic           found, xfer;
  st_e            cur_st, nxt_st;
  logic           hit;

  // A clear on a channel removes only that channel from arbitration.
  assign elig = ch_valid_i & ~ch_clear_i;

  // Rotating priority scan starting at rr_ptr_q; rr_ptr_q is always < NCH,
  // so a single subtract handles the wrap for non-power-of-two NCH.
  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = CHW'(idx);
      end
    end
  end

  assign xfer = found & ~reset_i;

  always_comb begin
    ch_ready_o = '0;
    if (xfer) ch_ready_o[grant] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;
  end

  // Fetch the granted context, then advance it with the shared detector.
  always_comb begin
    cur_st = S0;
    for (int i = 0; i < NCH; i++)
      if (grant == CHW'(i)) cur_st = ctx_q[i];
  end

  always_comb begin
    nxt_st = cur_st;
    hit    = 1'b0;
    unique case (cur_st)
      S0: nxt_st = ch_bit_i[grant] ? S1 : S0;
      S1: nxt_st = ch_bit_i[grant] ? S1 : S2;
      S2: nxt_st = ch_bit_i[grant] ? S3 : S0;
      S3: begin
        nxt_st = ch_bit_i[grant] ? S1 : S2;
        hit    = ~ch_bit_i[grant];
      end
      default: nxt_st = S0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctx_q       <= {NCH{S0}};
      rr_ptr_q    <= '0;
      det_valid_q <= 1'b0;
      det_ch_q    <= '0;
      det_hit_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_clear_i[i])                      ctx_q[i] <= S0;
        else if (xfer && grant == CHW'(i))      ctx_q[i] <= nxt_st;
      end
      rr_ptr_q    <= rr_ptr_d;
      det_valid_q <= xfer;
      det_ch_q    <= xfer ? grant : '0;
      det_hit_q   <= xfer & hit;
    end
  end

  assign det_valid_o = det_valid_q;
  assign det_ch_o    = det_ch_q;
  assign det_hit_o   = det_hit_q;

`ifdef HIT_COUNT_EN
  logic [NCH-1:0][CNTW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_clear_i[i])
          cnt_q[i] <= '0;
        else if (xfer && hit && grant == CHW'(i) && cnt_q[i] != {CNTW{1'b1}})
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  // Select by compare so indices >= NCH fall through to 0.
  always_comb begin
    cnt_val_o = '0;
    for (int i = 0; i < NCH; i++)
      if (cnt_sel_i == CHW'(i)) cnt_val_o = cnt_q[i];
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel_i;
  assign cnt_val_o      = '0;
`endif

endmodule

// File: tb/tb_seq_det_rr_sched.sv
module tb_seq_det_rr_sched;
  localparam int NCH = 4, CHW = 2, CNTW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  ch_valid, ch_bit, ch_clear, ch_ready;
  logic            det_valid, det_hit;
  logic [CHW-1:0]  det_ch, cnt_sel;
  logic [CNTW-1:0] cnt_val;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  seq_det_rr_sched #(.NCH(NCH), .CHW(CHW), .CNTW(CNTW)) dut (
    .clk_i(clk), .reset_i(reset), .ch_valid_i(ch_valid), .ch_bit_i(ch_bit),
    .ch_ready_o(ch_ready), .ch_clear_i(ch_clear), .det_valid_o(det_valid),
    .det_ch_o(det_ch), .det_hit_o(det_hit), .cnt_sel_i(cnt_sel),
    .cnt_val_o(cnt_val)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, check the combinational grant, clock once, check det_*.
  task automatic step(input string tag, input logic [3:0] v, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] exp_rdy,
                      input logic exp_dv, input logic [1:0] exp_ch, input logic exp_hit);
    ch_valid = v; ch_bit = b; ch_clear = c;
    #1;
    chk({tag, ".ready"}, ch_ready, exp_rdy);
    @(posedge clk); #1;
    chk({tag, ".dvalid"}, det_valid, exp_dv);
    chk({tag, ".dch"}, det_ch, exp_ch);
    chk({tag, ".dhit"}, det_hit, exp_hit);
  endtask

  task automatic do_reset();
    reset = 1'b1; ch_valid = '0; ch_bit = '0; ch_clear = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] bits4 [4];
    logic [1:0] exp_cnt [6];
    bits4 = '{4'hF, 4'h0, 4'hF, 4'h0};
    cnt_sel = '0;

    // T1: reset with all channels valid
    reset = 1'b1; ch_valid = 4'hF; ch_bit = 4'hF; ch_clear = '0;
    #1;
    chk("t1.ready_in_reset", ch_ready, 4'h0);
    @(posedge clk); #1;
    chk("t1.ready_in_reset2", ch_ready, 4'h0);
    @(posedge clk); #1;
    chk("t1.dvalid", det_valid, 1'b0);
    chk("t1.dch", det_ch, 2'd0);
    chk("t1.dhit", det_hit, 1'b0);
    reset = 1'b0; ch_valid = '0;
    // rr_ptr=0: with all valid the first grant must be ch0
    ch_valid = 4'hF; #1;
    chk("t1.first_grant", ch_ready, 4'h1);
    ch_valid = '0; #1;
    chk("t1.none_eligible", ch_ready, 4'h0);
    cnt_sel = 2'd0;
    chk("t1.cnt", cnt_val, 2'd0);

    // T2: ch0 1,0,1,0,1,0,0 -> hits after bits 4 and 6
    step("t2.b1", 4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0);
    step("t2.b2", 4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0);
    step("t2.b3", 4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0);
    step("t2.b4", 4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 1);
    step("t2.b5", 4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0);
    step("t2.b6", 4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 1);
    step("t2.b7", 4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0);
    step("t2.idle", 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);

    // T3: all four valid, round-robin, each fed 1,0,1,0
    do_reset();
    for (int c = 0; c < 16; c++)
      step($sformatf("t3.c%0d", c), 4'hF, bits4[c/4], 4'h0, 4'(1 << (c % 4)),
           1, 2'(c % 4), (c >= 12));

    // T4: ch1 context survives ch2 traffic
    do_reset();
    step("t4.a1", 4'h2, 4'h2, 4'h0, 4'h2, 1, 1, 0);
    step("t4.a2", 4'h2, 4'h0, 4'h0, 4'h2, 1, 1, 0);
    step("t4.a3", 4'h2, 4'h2, 4'h0, 4'h2, 1, 1, 0);
    step("t4.o1", 4'h4, 4'h4, 4'h0, 4'h4, 1, 2, 0);
    step("t4.o2", 4'h4, 4'h0, 4'h0, 4'h4, 1, 2, 0);
    step("t4.o3", 4'h4, 4'h4, 4'h0, 4'h4, 1, 2, 0);
    step("t4.o4", 4'h4, 4'h0, 4'h0, 4'h4, 1, 2, 1);
    step("t4.o5", 4'h4, 4'h0, 4'h0, 4'h4, 1, 2, 0);
    step("t4.a4", 4'h2, 4'h0, 4'h0, 4'h2, 1, 1, 1);

    // T5: clear ch3 mid-pattern; ch0 still granted in the clear cycle
    do_reset();
    step("t5.a1", 4'h8, 4'h8, 4'h0, 4'h8, 1, 3, 0);
    step("t5.a2", 4'h8, 4'h0, 4'h0, 4'h8, 1, 3, 0);
    step("t5.a3", 4'h8, 4'h8, 4'h0, 4'h8, 1, 3, 0);
    step("t5.clr", 4'h9, 4'h0, 4'h8, 4'h1, 1, 0, 0);
    step("t5.clr_only", 4'h8, 4'h0, 4'h8, 4'h0, 0, 0, 0);
    step("t5.a4", 4'h8, 4'h0, 4'h0, 4'h8, 1, 3, 0);

`ifdef HIT_COUNT_EN
    // T6: saturating counter on ch0, CNTW=2
    do_reset();
    exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    cnt_sel = 2'd0;
    for (int n = 1; n <= 12; n++) begin
      step($sformatf("t6.b%0d", n), 4'h1, (n % 2 == 1) ? 4'h1 : 4'h0, 4'h0, 4'h1,
           1, 0, (n >= 4 && n % 2 == 0));
      chk($sformatf("t6.cnt%0d", n), cnt_val, exp_cnt[(n >= 4) ? n / 2 - 1 : 0]);
    end
    cnt_sel = 2'd1; #1;
    chk("t6.cnt_ch1", cnt_val, 2'd0);
    cnt_sel = 2'd0;
    step("t6.m1", 4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0);
    step("t6.m2", 4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 1);
    step("t6.m3", 4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0);
    do_reset();
    chk("t6.cnt_after_reset", cnt_val, 2'd0);
    step("t6.r1", 4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0);
    step("t6.r2", 4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0);
    step("t6.r3", 4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0);
    chk("t6.cnt_final", cnt_val, 2'd0);
`else
    cnt_sel = 2'd3; #1;
    chk("t6.cnt_tied0", cnt_val, 2'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
